// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch PC sequencer with a single outstanding
// memory request, a one-entry output buffer toward ID, and a one-entry
// capture slot for a response that arrives while that buffer is still full.
// Control flow redirects from ID take priority over everything else.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap odd redirect
// targets to TRAP_VEC and report them on misalign_o/misalign_addr_o;
// without it, bit 0 of the target is cleared and the redirect proceeds.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic [31:0] brj_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        flush_o,
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic        kill_q;

  // Response captured while the output buffer was still occupied
  logic        pend_valid;
  logic [31:0] pend_instr;
  logic [31:0] pend_pc;

  logic        redirect;
  logic        consume;
  logic [31:0] target;
  logic [31:0] seq_step;

  assign redirect = id_valid_i & (branch_i | jump_i);
  assign consume  = instr_valid_o & instr_ready_i;

  // Compressed encodings have low bits other than 2'b11
  assign seq_step = (imem_rdata_i[1:0] != 2'b11) ? 32'd2 : 32'd4;

  assign imem_req_o  = (state == REQ);
  assign imem_addr_o = (state == REQ) ? pc_q : 32'h0000_0000;
  assign flush_o     = redirect & ~rst_i;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;

  assign misaligned = brj_pc_i[0];
  assign target     = misaligned ? TRAP_VEC : brj_pc_i;

  // One-cycle misalignment report; the address holds until the next trap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misalign_o      <= 1'b0;
      misalign_addr_o <= 32'h0000_0000;
    end else begin
      misalign_o <= redirect & misaligned;
      if (redirect & misaligned) begin
        misalign_addr_o <= brj_pc_i;
      end
    end
  end
`else
  logic unused_cfg;

  assign target          = {brj_pc_i[31:1], 1'b0};
  assign misalign_o      = 1'b0;
  assign misalign_addr_o = 32'h0000_0000;
  assign unused_cfg      = ^{TRAP_VEC, brj_pc_i[0]};
`endif

  // Fetch FSM, PC, kill flag, output buffer and capture slot
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= BOOT;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      instr_valid_o <= 1'b0;
      instr_o       <= 32'h0000_0000;
      instr_pc_o    <= 32'h0000_0000;
      pend_valid    <= 1'b0;
      pend_instr    <= 32'h0000_0000;
      pend_pc       <= 32'h0000_0000;
    end else if (redirect) begin
      // Redirect wins over capture and consumption: drop everything buffered
      pc_q          <= target;
      instr_valid_o <= 1'b0;
      pend_valid    <= 1'b0;
      case (state)
        BOOT: state <= REQ;
        REQ: begin
          // A request accepted this cycle now fetches a stale address
          if (imem_gnt_i) begin
            state  <= RESP;
            kill_q <= 1'b1;
          end
        end
        RESP: begin
          // Nothing left in flight once the response is here or was captured
          if (imem_rvalid_i || pend_valid) begin
            state  <= REQ;
            kill_q <= 1'b0;
          end else begin
            kill_q <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end else begin
      if (consume) begin
        instr_valid_o <= 1'b0;
      end
      case (state)
        BOOT: state <= REQ;
        REQ: begin
          if (imem_gnt_i) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (pend_valid) begin
            // Waiting for ID to drain the buffer before moving the capture in
            if (consume) begin
              instr_valid_o <= 1'b1;
              instr_o       <= pend_instr;
              instr_pc_o    <= pend_pc;
              pend_valid    <= 1'b0;
              state         <= REQ;
            end
          end else if (imem_rvalid_i) begin
            if (kill_q) begin
              kill_q <= 1'b0;
              state  <= REQ;
            end else begin
              pc_q <= pc_q + seq_step;
              if (!instr_valid_o || consume) begin
                instr_valid_o <= 1'b1;
                instr_o       <= imem_rdata_i;
                instr_pc_o    <= pc_q;
                state         <= REQ;
              end else begin
                pend_valid <= 1'b1;
                pend_instr <= imem_rdata_i;
                pend_pc    <= pc_q;
              end
            end
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed bench for fetch_pc_unit. A small memory
// responder serves requests; a reference model tracks the expected fetch
// address and the ordered list of instruction addresses that must reach ID,
// and a negedge process compares the DUT against it every cycle.
// Honours FETCH_MISALIGN_TRAP_EN the same way as the design.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk;
  logic        rst_i;
  logic        id_valid_i;
  logic        branch_i;
  logic        jump_i;
  logic [31:0] brj_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        flush_o;
  logic        misalign_o;
  logic [31:0] misalign_addr_o;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit #(
    .RESET_PC(RESET_PC),
    .TRAP_VEC(TRAP_VEC)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .branch_i       (branch_i),
    .jump_i         (jump_i),
    .brj_pc_i       (brj_pc_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .instr_valid_o  (instr_valid_o),
    .instr_o        (instr_o),
    .instr_pc_o     (instr_pc_o),
    .instr_ready_i  (instr_ready_i),
    .flush_o        (flush_o),
    .misalign_o     (misalign_o),
    .misalign_addr_o(misalign_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: fixed words at 0/4/6, a pattern elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0000_4501;
    if (a == 32'h6) return 32'h0000_0013;
    return a[3] ? {a[23:0], 8'h01} : {a[23:0], 8'h13};
  endfunction

  function automatic logic [31:0] ilen(input logic [31:0] w);
    return (w[1:0] == 2'b11) ? 32'd4 : 32'd2;
  endfunction

  function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return t[0] ? TRAP_VEC : t;
`else
    return {t[31:1], 1'b0};
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Memory responder: grants when idle, answers lat cycles after the grant
  int          lat = 1;
  bit          gnt_en = 1'b1;
  int          cnt = 0;
  logic [31:0] resp_addr = 32'h0;

  always @(posedge clk) begin
    #1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'hDEAD_BEEF;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(resp_addr);
      end
    end else if (imem_req_o && gnt_en) begin
      imem_gnt_i = 1'b1;
      cnt        = lat;
      resp_addr  = imem_addr_o;
    end
  end

  // Reference model state
  logic [31:0] q[$];
  logic [31:0] fetch_pc_m = RESET_PC;
  bit          outst = 1'b0;
  bit          live = 1'b0;
  logic [31:0] out_addr = 32'h0;
  bit          exp_mis = 1'b0;
  logic [31:0] exp_mis_addr = 32'h0;

  // Per-cycle comparison against the model, then model update
  always @(negedge clk) begin
    bit redir;
    redir = id_valid_i & (branch_i | jump_i);
    if (rst_i) begin
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_flush", 32'(flush_o), 32'd0);
      chk("rst_valid", 32'(instr_valid_o), 32'd0);
      chk("rst_misalign", 32'(misalign_o), 32'd0);
      chk("rst_misalign_addr", misalign_addr_o, 32'd0);
      q.delete();
      fetch_pc_m   = RESET_PC;
      outst        = 1'b0;
      live         = 1'b0;
      exp_mis      = 1'b0;
      exp_mis_addr = 32'h0;
    end else begin
      chk("flush", 32'(flush_o), 32'(redir));
      chk("valid", 32'(instr_valid_o), 32'(q.size() > 0));
      if (instr_valid_o && q.size() > 0) begin
        chk("instr_pc", instr_pc_o, q[0]);
        chk("instr", instr_o, mem_word(q[0]));
      end
      chk("req_blocked", 32'(imem_req_o && (outst || q.size() >= 2)), 32'd0);
      if (imem_req_o) chk("fetch_addr", imem_addr_o, fetch_pc_m);
      chk("misalign", 32'(misalign_o), 32'(exp_mis));
      if (exp_mis) chk("misalign_addr", misalign_addr_o, exp_mis_addr);
`ifndef FETCH_MISALIGN_TRAP_EN
      chk("misalign_addr_tied", misalign_addr_o, 32'd0);
`endif
      if (redir) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_mis = brj_pc_i[0];
        if (brj_pc_i[0]) exp_mis_addr = brj_pc_i;
`else
        exp_mis = 1'b0;
`endif
        fetch_pc_m = eff_target(brj_pc_i);
        q.delete();
        if (outst && imem_rvalid_i) outst = 1'b0;
        else if (outst) live = 1'b0;
        if (imem_req_o && imem_gnt_i) begin
          outst = 1'b1;
          live  = 1'b0;
        end
      end else begin
        exp_mis = 1'b0;
        if (instr_valid_o && instr_ready_i && q.size() > 0) void'(q.pop_front());
        if (outst && imem_rvalid_i) begin
          outst = 1'b0;
          if (live) begin
            q.push_back(out_addr);
            fetch_pc_m = out_addr + ilen(mem_word(out_addr));
          end
        end
        if (imem_req_o && imem_gnt_i) begin
          outst    = 1'b1;
          live     = 1'b1;
          out_addr = fetch_pc_m;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // sel: 0 grant, 1 rvalid, 2 request, 3 instr_valid
  task automatic wait_sig(input string nm, input int sel);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 100) begin
      case (sel)
        0: hit = imem_gnt_i;
        1: hit = imem_rvalid_i;
        2: hit = imem_req_o;
        default: hit = instr_valid_o;
      endcase
      if (!hit) begin
        step();
        n++;
      end
    end
    chk({nm, "_timeout"}, 32'(hit), 32'd1);
  endtask

  task automatic wait_consume(input string nm, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    wait_sig(nm, 3);
    chk({nm, "_pc"}, instr_pc_o, exp_pc);
    chk({nm, "_instr"}, instr_o, exp_instr);
    step();
  endtask

  // Park the DUT in REQ with no grant, redirect, and check the next address
  task automatic redirect_in_req(input string nm, input logic [31:0] t,
                                 input logic [31:0] exp_addr, input logic exp_m);
    gnt_en = 1'b0;
    step();
    wait_sig({nm, "_park"}, 2);
    id_valid_i = 1'b1;
    jump_i     = 1'b1;
    brj_pc_i   = t;
    #1;
    chk({nm, "_flush"}, 32'(flush_o), 32'd1);
    step();
    id_valid_i = 1'b0;
    jump_i     = 1'b0;
    chk({nm, "_req"}, 32'(imem_req_o), 32'd1);
    chk({nm, "_addr"}, imem_addr_o, exp_addr);
    chk({nm, "_mis"}, 32'(misalign_o), 32'(exp_m));
    if (exp_m) chk({nm, "_mis_addr"}, misalign_addr_o, t);
    step();
    chk({nm, "_mis_clear"}, 32'(misalign_o), 32'd0);
    chk({nm, "_addr_hold"}, imem_addr_o, exp_addr);
    gnt_en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen_req;
    rst_i         = 1'b1;
    id_valid_i    = 1'b1;
    branch_i      = 1'b0;
    jump_i        = 1'b1;
    brj_pc_i      = 32'h0000_0500;
    instr_ready_i = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    repeat (2) step();
    id_valid_i = 1'b0;
    jump_i     = 1'b0;
    rst_i      = 1'b0;
    #1;
    chk("boot_req", 32'(imem_req_o), 32'd0);
    chk("boot_valid", 32'(instr_valid_o), 32'd0);
    step();
    chk("first_req", 32'(imem_req_o), 32'd1);
    chk("first_addr", imem_addr_o, RESET_PC);

    // Sequential fetch: 32-bit, compressed, 32-bit
    wait_consume("seq0", 32'h0, 32'h0000_0013);
    wait_consume("seq1", 32'h4, 32'h0000_4501);
    wait_consume("seq2", 32'h6, 32'h0000_0013);

    // Branch without ID valid is not a redirect
    branch_i = 1'b1;
    #1;
    chk("nonvalid_flush", 32'(flush_o), 32'd0);
    repeat (2) step();
    branch_i = 1'b0;

    // Redirect while waiting for a response: stale data dropped
    lat = 3;
    wait_sig("rsp_gnt", 0);
    step();
    id_valid_i = 1'b1;
    branch_i   = 1'b1;
    brj_pc_i   = 32'h0000_0200;
    #1;
    chk("rsp_flush", 32'(flush_o), 32'd1);
    step();
    id_valid_i = 1'b0;
    branch_i   = 1'b0;
    #1;
    chk("rsp_flush_pulse", 32'(flush_o), 32'd0);
    n = 0;
    seen_req = 1'b0;
    while (!seen_req && n < 20) begin
      chk("rsp_stale_valid", 32'(instr_valid_o), 32'd0);
      seen_req = imem_req_o;
      if (!seen_req) begin
        step();
        n++;
      end
    end
    chk("rsp_req_seen", 32'(seen_req), 32'd1);
    chk("rsp_addr", imem_addr_o, 32'h0000_0200);
    wait_consume("rsp_tgt", 32'h0000_0200, 32'h0002_0013);

    // Redirect in REQ without grant
    lat = 1;
    redirect_in_req("req_nognt", 32'h0000_0080, 32'h0000_0080, 1'b0);
    wait_consume("req_nognt_tgt", 32'h0000_0080, 32'h0000_8013);

    // Redirect in the same cycle as a grant: response killed
    wait_sig("req_gnt", 0);
    id_valid_i = 1'b1;
    jump_i     = 1'b1;
    brj_pc_i   = 32'h0000_00C0;
    step();
    id_valid_i = 1'b0;
    jump_i     = 1'b0;
    chk("kill_valid", 32'(instr_valid_o), 32'd0);
    wait_sig("kill_req", 2);
    chk("kill_addr", imem_addr_o, 32'h0000_00C0);
    wait_consume("kill_tgt", 32'h0000_00C0, 32'h0000_C013);

    // ID stall with buffer and capture slot both full
    instr_ready_i = 1'b0;
    id_valid_i    = 1'b1;
    jump_i        = 1'b1;
    brj_pc_i      = 32'h0000_0040;
    step();
    id_valid_i = 1'b0;
    jump_i     = 1'b0;
    wait_sig("stall_fill", 3);
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", 32'(imem_req_o), 32'd0);
      chk("stall_valid", 32'(instr_valid_o), 32'd1);
      chk("stall_pc", instr_pc_o, 32'h0000_0040);
      chk("stall_instr", instr_o, 32'h0000_4013);
      step();
    end
    instr_ready_i = 1'b1;
    wait_consume("stall_c0", 32'h0000_0040, 32'h0000_4013);
    wait_consume("stall_c1", 32'h0000_0044, 32'h0000_4413);

    // Redirect in the same cycle as rvalid
    lat = 2;
    wait_sig("rv_rvalid", 1);
    id_valid_i = 1'b1;
    branch_i   = 1'b1;
    brj_pc_i   = 32'h0000_0300;
    step();
    id_valid_i = 1'b0;
    branch_i   = 1'b0;
    chk("rv_req", 32'(imem_req_o), 32'd1);
    chk("rv_addr", imem_addr_o, 32'h0000_0300);
    chk("rv_valid", 32'(instr_valid_o), 32'd0);
    wait_consume("rv_tgt", 32'h0000_0300, 32'h0003_0013);

    // Odd redirect target
    lat = 1;
`ifdef FETCH_MISALIGN_TRAP_EN
    redirect_in_req("odd", 32'h0000_0301, 32'h0000_0100, 1'b1);
    wait_consume("odd_tgt", 32'h0000_0100, 32'h0001_0013);
`else
    redirect_in_req("odd", 32'h0000_0301, 32'h0000_0300, 1'b0);
    wait_consume("odd_tgt", 32'h0000_0300, 32'h0003_0013);
`endif

    // Reset in the middle of a response, rvalid lands in BOOT
    lat = 3;
    wait_sig("mid_gnt", 0);
    step();
    rst_i = 1'b1;
    #1;
    chk("mid_rst_req", 32'(imem_req_o), 32'd0);
    chk("mid_rst_valid", 32'(instr_valid_o), 32'd0);
    repeat (2) step();
    rst_i = 1'b0;
    #1;
    chk("mid_boot_req", 32'(imem_req_o), 32'd0);
    step();
    chk("mid_first_req", 32'(imem_req_o), 32'd1);
    chk("mid_first_addr", imem_addr_o, RESET_PC);
    wait_consume("mid_c0", 32'h0, 32'h0000_0013);
    wait_consume("mid_c1", 32'h4, 32'h0000_4501);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0100, redirect target on misaligned branch/jump (Configuration only).
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports id_valid_i  input  1 (ID-stage instruction valid); branch_i  input  1 (conditional branch taken); jump_i  input  1 (JAL/JALR); brj_pc_i  input  32 (branch/jump target).
REQ-006 SHALL have ports imem_req_o  output  1; imem_addr_o  output  32; imem_gnt_i  input  1 (request accepted); imem_rvalid_i  input  1; imem_rdata_i  input  32.
REQ-007 SHALL have ports instr_valid_o  output  1; instr_o  output  32; instr_pc_o  output  32; instr_ready_i  input  1 (ID accepts).
REQ-008 SHALL have ports flush_o  output  1 (IF/ID flush pulse); misalign_o  output  1; misalign_addr_o  output  32.

Function
REQ-009 SHALL implement states BOOT, REQ, RESP; BOOT -> REQ unconditionally one cycle after reset release.
REQ-010 SHALL drive imem_req_o=1 and imem_addr_o=pc_q only in REQ; REQ -> RESP on imem_gnt_i.
REQ-011 SHALL stay in RESP until imem_rvalid_i; at most one outstanding request.
REQ-012 SHALL, on rvalid with no kill, load a one-entry output buffer (instr_o=imem_rdata_i, instr_pc_o=pc_q, instr_valid_o=1) next cycle, and advance pc_q by 2 if imem_rdata_i[1:0]!=2'b11 (compressed), else 4; 32-bit wrap-around, no overflow flag.
REQ-013 SHALL hold the output buffer stable while instr_valid_o=1 and instr_ready_i=0; entry cleared on valid&ready.
REQ-014 SHALL leave RESP for REQ only if the buffer is empty or consumed that cycle; otherwise wait in RESP with data captured (no new request).
REQ-015 SHALL treat redirect = id_valid_i & (branch_i | jump_i); on redirect: pc_q <= target, buffer cleared, flush_o=1 for exactly that cycle (combinational).
REQ-016 SHALL, on redirect in RESP before rvalid, set kill_q; returned data discarded, kill_q cleared on that rvalid, then -> REQ with new pc_q.
REQ-017 SHALL, on redirect in REQ with imem_gnt_i same cycle, go to RESP with kill_q=1; without gnt, stay in REQ and present new address next cycle.
REQ-018 SHALL give redirect priority over simultaneous rvalid capture and buffer consumption; redirect with rvalid in same cycle discards the data, no kill_q set.
REQ-019 SHALL latency: redirect at cycle N -> imem_req_o with target at N+1 when no request outstanding.

Reset
REQ-020 SHALL on rst_i asynchronously set: state=BOOT, pc_q=RESET_PC, kill_q=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, misalign_o=0, misalign_addr_o=0; imem_req_o=0 and flush_o=0 while reset asserted.
REQ-021 SHALL, on reset mid-transaction, discard any in-flight response; rvalid arriving in BOOT ignored.

Configuration
REQ-022 SHALL use macro FETCH_MISALIGN_TRAP_EN.
REQ-023 SHALL, with macro defined, on redirect with brj_pc_i[0]=1: pc_q <= TRAP_VEC, misalign_o=1 one cycle (registered), misalign_addr_o <= brj_pc_i; flush as normal.
REQ-024 SHALL, without macro, force target bit 0 to 0 and redirect normally; misalign_o and misalign_addr_o tied 0.

Verification
REQ-025 Reset release, gnt/rvalid same-cycle-after, rdata 32'h0000_0013, ready=1 -> instr_pc_o 0, then 4; rdata 32'h0000_4501 -> next PC +2.
REQ-026 Redirect to 32'h0000_0200 while in RESP -> flush_o one cycle, stale rdata dropped (instr_valid_o stays 0), next imem_addr_o 32'h200.
REQ-027 instr_ready_i=0 for 5 cycles with buffer full -> instr_o/instr_pc_o stable, imem_req_o=0 throughout.
REQ-028 Redirect and rvalid in same cycle -> data discarded, imem_addr_o = target next cycle.
REQ-029 Target 32'h0000_0301: macro on -> misalign_o=1, misalign_addr_o=32'h301, fetch at 32'h100; macro off -> fetch at 32'h300.
REQ-030 rst_i asserted mid-RESP, late rvalid -> ignored; first fetch after release at RESET_PC.
